// File: rtl/button_events_if.sv
// Two-channel button event bus.
//   en     : setting-mode enable (registered switch level)
//   press1 : channel-1 pressed level, active high
//   press2 : channel-2 pressed level, active high
//   evt1/2 : one-cycle increment events
//   held1/2: debounced-pressed levels
// master = upstream driver / event consumer, slave = button_events.
interface button_events_if;
   logic en;
   logic press1;
   logic press2;
   logic evt1;
   logic evt2;
   logic held1;
   logic held2;

   modport master (
      output en, press1, press2,
      input  evt1, evt2, held1, held2
   );

   modport slave (
      input  en, press1, press2,
      output evt1, evt2, held1, held2
   );
endinterface

// File: rtl/button_events.sv
// Two-channel debounce, press-event and auto-repeat stage.
// Ports:
//   clk   : system clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : button_events_if.slave (en, press1/2 in; evt1/2, held1/2 out)
// Each channel debounces its pressed level, emits one evt on an accepted
// press, starts auto-repeat after HOLD_CYCLES and repeats every
// REPEAT_CYCLES while held. All outputs come from flops.
module button_events #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES     = 10,
   parameter int unsigned REPEAT_CYCLES   = 3,
   parameter int unsigned CNT_W           = 16
) (
   input logic             clk,
   input logic             rst_n,
   button_events_if.slave  bus
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_DEB_PRESS   = 3'd1;
   localparam logic [2:0] S_PRESSED     = 3'd2;
   localparam logic [2:0] S_REPEAT      = 3'd3;
   localparam logic [2:0] S_DEB_RELEASE = 3'd4;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]            press;
   logic [1:0][2:0]       state_q, state_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            evt_q, evt_d;
   logic [1:0]            held;

   assign press = {bus.press2, bus.press1};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         if (!bus.en) begin
            state_d[ch] = S_IDLE;
            cnt_d[ch]   = '0;
         end else begin
            case (state_q[ch])
               S_IDLE: begin
                  if (press[ch]) begin
                     state_d[ch] = S_DEB_PRESS;
                     cnt_d[ch]   = CNT_ONE;
                  end
               end
               S_DEB_PRESS: begin
                  if (!press[ch]) begin
                     state_d[ch] = S_IDLE;
                     cnt_d[ch]   = '0;
                  end else if (cnt_q[ch] == DEB_LAST) begin
                     state_d[ch] = S_PRESSED;
                     cnt_d[ch]   = '0;
                     evt_d[ch]   = 1'b1;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                  end
               end
               S_PRESSED: begin
                  if (!press[ch]) begin
                     state_d[ch] = S_DEB_RELEASE;
                     cnt_d[ch]   = CNT_ONE;
                  end else if (cnt_q[ch] == HOLD_LAST) begin
                     state_d[ch] = S_REPEAT;
                     cnt_d[ch]   = '0;
                     evt_d[ch]   = 1'b1;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                  end
               end
               S_REPEAT: begin
                  if (!press[ch]) begin
                     state_d[ch] = S_DEB_RELEASE;
                     cnt_d[ch]   = CNT_ONE;
                  end else if (cnt_q[ch] == REP_LAST) begin
                     cnt_d[ch] = '0;
                     evt_d[ch] = 1'b1;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                  end
               end
               S_DEB_RELEASE: begin
                  // A bounce back to pressed restarts the hold timer silently.
                  if (press[ch]) begin
                     state_d[ch] = S_PRESSED;
                     cnt_d[ch]   = '0;
                  end else if (cnt_q[ch] == DEB_LAST) begin
                     state_d[ch] = S_IDLE;
                     cnt_d[ch]   = '0;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                  end
               end
               default: begin
                  state_d[ch] = S_IDLE;
                  cnt_d[ch]   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         cnt_q   <= '0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

   // held is a decode of registered state, so it has no input path and
   // clears together with the async reset.
   always_comb begin
      held = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         held[ch] = (state_q[ch] == S_PRESSED) ||
                    (state_q[ch] == S_REPEAT)  ||
                    (state_q[ch] == S_DEB_RELEASE);
      end
   end

   assign bus.evt1  = evt_q[0];
   assign bus.evt2  = evt_q[1];
   assign bus.held1 = held[0];
   assign bus.held2 = held[1];

endmodule

// File: tb/tb_button_events.sv
// Directed self-checking bench for button_events (default parameters).
// Inputs change 1ns after posedge; outputs are sampled at the same point,
// so "step k" observes the result of the k-th edge after a stimulus change.
module tb_button_events;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   button_events_if bus ();

   button_events #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (3),
      .CNT_W           (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.en = 1'b1;
      bus.press1 = 1'b0;
      bus.press2 = 1'b0;
      #3;
      n_cmp++;
      if ({bus.evt1, bus.evt2, bus.held1, bus.held2} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 0000",
                  {bus.evt1, bus.evt2, bus.held1, bus.held2});
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      n_cmp++;
      if ({bus.evt1, bus.evt2, bus.held1, bus.held2} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_release_idle: got %b want 0000",
                  {bus.evt1, bus.evt2, bus.held1, bus.held2});
      end
   endtask

   task automatic test_single_press();
      bus.press1 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1, bus.evt2, bus.held2} !==
             {(k == 4), (k >= 4), 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_press k=%0d: got e1h1e2h2=%b want %b", k,
                     {bus.evt1, bus.held1, bus.evt2, bus.held2},
                     {(k == 4), (k >= 4), 2'b00});
         end
      end
      bus.press1 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1, bus.evt2, bus.held2} !==
             {1'b0, (k < 4), 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_release k=%0d: got e1h1e2h2=%b want %b", k,
                     {bus.evt1, bus.held1, bus.evt2, bus.held2},
                     {1'b0, (k < 4), 2'b00});
         end
      end
   endtask

   task automatic test_glitch();
      // 3 high, 1 low, 3 high, then low: never reaches 4 stable samples.
      logic [7:0] pattern;
      pattern = 8'b0111_0111;
      for (int k = 0; k < 8; k++) begin
         bus.press1 = pattern[k];
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1} !== 2'b00) begin
            n_err++;
            $display("FAIL glitch k=%0d: got evt1,held1=%b want 00", k,
                     {bus.evt1, bus.held1});
         end
      end
      bus.press1 = 1'b0;
      step();
   endtask

   task automatic test_repeat();
      logic exp_evt;
      bus.press2 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         exp_evt = (k == 4) || (k == 14) || (k > 14 && ((k - 14) % 3) == 0);
         n_cmp++;
         if ({bus.evt2, bus.held2, bus.evt1} !== {exp_evt, (k >= 4), 1'b0}) begin
            n_err++;
            $display("FAIL repeat k=%0d: got evt2,held2,evt1=%b want %b", k,
                     {bus.evt2, bus.held2, bus.evt1}, {exp_evt, (k >= 4), 1'b0});
         end
      end
      bus.press2 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if ({bus.evt2, bus.held2} !== {1'b0, (k < 4)}) begin
            n_err++;
            $display("FAIL repeat_release k=%0d: got evt2,held2=%b want %b", k,
                     {bus.evt2, bus.held2}, {1'b0, (k < 4)});
         end
      end
   endtask

   task automatic test_dropout();
      bus.press1 = 1'b1;
      for (int k = 1; k <= 6; k++) step();
      bus.press1 = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1} !== 2'b01) begin
            n_err++;
            $display("FAIL dropout_low k=%0d: got evt1,held1=%b want 01", k,
                     {bus.evt1, bus.held1});
         end
      end
      bus.press1 = 1'b1;
      // Edge 1 re-enters PRESSED with cnt=0; first repeat 10 edges later.
      for (int j = 1; j <= 12; j++) begin
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1} !== {(j == 11), 1'b1}) begin
            n_err++;
            $display("FAIL dropout_hold j=%0d: got evt1,held1=%b want %b", j,
                     {bus.evt1, bus.held1}, {(j == 11), 1'b1});
         end
      end
      bus.press1 = 1'b0;
      for (int k = 1; k <= 5; k++) step();
   endtask

   task automatic test_back_to_back();
      logic exp_evt;
      bus.press1 = 1'b1;
      bus.press2 = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_evt = (k == 4) || (k == 14) || (k > 14 && ((k - 14) % 3) == 0);
         n_cmp++;
         if ({bus.evt1, bus.evt2, bus.held1, bus.held2} !==
             {exp_evt, exp_evt, (k >= 4), (k >= 4)}) begin
            n_err++;
            $display("FAIL simultaneous k=%0d: got e1e2h1h2=%b want %b", k,
                     {bus.evt1, bus.evt2, bus.held1, bus.held2},
                     {exp_evt, exp_evt, (k >= 4), (k >= 4)});
         end
      end
      bus.press1 = 1'b0;
      bus.press2 = 1'b0;
      for (int k = 1; k <= 5; k++) step();
   endtask

   task automatic test_async_reset();
      bus.press1 = 1'b1;
      for (int k = 1; k <= 17; k++) step();
      n_cmp++;
      if ({bus.evt1, bus.held1} !== 2'b11) begin
         n_err++;
         $display("FAIL pre_reset_repeat: got evt1,held1=%b want 11",
                  {bus.evt1, bus.held1});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.evt1, bus.held1} !== 2'b00) begin
         n_err++;
         $display("FAIL async_reset: got evt1,held1=%b want 00",
                  {bus.evt1, bus.held1});
      end
      step();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if ({bus.evt1, bus.held1} !== {(k == 4), (k >= 4)}) begin
            n_err++;
            $display("FAIL post_reset k=%0d: got evt1,held1=%b want %b", k,
                     {bus.evt1, bus.held1}, {(k == 4), (k >= 4)});
         end
      end
      bus.press1 = 1'b0;
      for (int k = 1; k <= 5; k++) step();
   endtask

   task automatic test_enable();
      bus.press2 = 1'b1;
      for (int k = 1; k <= 8; k++) step();
      n_cmp++;
      if (bus.held2 !== 1'b1) begin
         n_err++;
         $display("FAIL en_pre_hold: got held2=%b want 1", bus.held2);
      end
      bus.en = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         step();
         n_cmp++;
         if ({bus.evt2, bus.held2} !== 2'b00) begin
            n_err++;
            $display("FAIL en_low k=%0d: got evt2,held2=%b want 00", k,
                     {bus.evt2, bus.held2});
         end
      end
      // Press still active when enable returns: debounced as a new press.
      bus.en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if ({bus.evt2, bus.held2} !== {(k == 4), (k >= 4)}) begin
            n_err++;
            $display("FAIL en_rise k=%0d: got evt2,held2=%b want %b", k,
                     {bus.evt2, bus.held2}, {(k == 4), (k >= 4)});
         end
      end
      bus.press2 = 1'b0;
      for (int k = 1; k <= 5; k++) step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single_press();
      test_glitch();
      test_repeat();
      test_dropout();
      test_back_to_back();
      test_async_reset();
      test_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
